// File: rtl/elastic_fifo_struct_pkg.sv
// ---------------------------------------------------------------------------
// elastic_fifo_struct_pkg
// Purpose : generic utilities shared by the elastic FIFO and its pointer
//           counters. Holds the modulo pointer increment, which works for any
//           modulus including non powers of two, and the handshake
//           classification used to update occupancy.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package elastic_fifo_struct_pkg;

    // Combined push/pop activity of one cycle; the bit order is {push, pop}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifoOp_e;

    // Advance a pointer by one and wrap from modulus-1 back to 0.
    // The >= comparison also folds any out-of-range value back to 0.
    function automatic logic [31:0] ptr_inc(input logic [31:0] value,
                                            input int unsigned modulus);
        logic [31:0] lastIdx;
        lastIdx = modulus - 32'd1;
        if (value >= lastIdx) begin
            return 32'd0;
        end
        return value + 32'd1;
    endfunction

endpackage

// File: rtl/elastic_fifo_struct_wrap_counter.sv
// ---------------------------------------------------------------------------
// wrap_counter
// Purpose : modulo-MOD counter used as the head and tail pointer of the
//           elastic FIFO. Counts 0..MOD-1 and wraps; clear has priority over
//           increment.
// Ports   : clk      - rising-edge clock
//           reset    - synchronous active-high reset, value returns to 0
//           clear_i  - synchronous clear to 0 (used for flush)
//           en_i     - advance by one this cycle
//           value_o  - current pointer value
// ---------------------------------------------------------------------------
module wrap_counter
    import elastic_fifo_struct_pkg::*;
#(
    parameter int unsigned MOD = 4,
    parameter int unsigned W   = (MOD > 1) ? $clog2(MOD) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         en_i,
    output logic [W-1:0] value_o
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    // Next pointer: clear wins over increment so a squash always lands on 0
    // even when a handshake is reported in the same cycle.
    always_comb begin
        value_d = value_q;
        if (clear_i) begin
            value_d = '0;
        end else if (en_i) begin
            value_d = W'(ptr_inc(32'(value_q), MOD));
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/elastic_fifo_struct.sv
// ---------------------------------------------------------------------------
// elastic_fifo_struct
// Purpose : valid/ready elastic buffer carrying a parameterised payload type
//           T (any packed type or struct). DEPTH entries, any DEPTH >= 2.
//           One push and one pop per cycle sustained at every occupancy,
//           including a push into a full buffer while it is being drained.
//           flush squashes all stored entries synchronously.
// Config  : ELASTIC_FIFO_BYPASS_EN - when defined, an item offered to an empty
//           buffer is presented on data_out in the same cycle and, if taken,
//           passes through without being stored. When undefined there is no
//           combinational path from data_in/valid_in to any output.
// Ports   : clk       - rising-edge clock
//           reset     - synchronous active-high reset (beats flush/push/pop)
//           flush     - synchronous discard of all entries (beats push/pop)
//           valid_in  - producer offers data_in
//           ready_in  - buffer accepts data_in this cycle
//           data_in   - producer payload
//           valid_out - data_out holds a valid entry
//           ready_out - consumer takes data_out this cycle
//           data_out  - oldest entry
//           count     - occupancy 0..DEPTH
//           full      - count == DEPTH
//           empty     - count == 0
// ---------------------------------------------------------------------------
module elastic_fifo_struct
    import elastic_fifo_struct_pkg::*;
#(
    parameter type         T     = logic,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             valid_in,
    output logic             ready_in,
    input  T                 data_in,
    output logic             valid_out,
    input  logic             ready_out,
    output T                 data_out,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned      PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    T                 storage_q [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [PTR_W-1:0] headPtr;
    logic [PTR_W-1:0] tailPtr;

    logic    pushHs;
    logic    popHs;
    logic    storeEn;
    logic    headEn;
    fifoOp_e op;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign count = count_q;

    // A full buffer still accepts when the head leaves on the same edge, so
    // ready_in depends combinationally on ready_out.
    assign ready_in = (!full || ready_out) && !flush;
    assign pushHs   = valid_in && ready_in;
    assign popHs    = valid_out && ready_out;

`ifdef ELASTIC_FIFO_BYPASS_EN
    logic bypassActive;

    // While empty the offered item is shown directly. If the consumer takes it
    // the push and pop cancel and nothing touches storage or pointers; if not,
    // it is written normally and is still the head next cycle.
    assign bypassActive = empty && valid_in && !flush;
    assign valid_out    = (!empty || valid_in) && !flush;
    assign data_out     = bypassActive ? data_in : storage_q[headPtr];
    assign storeEn      = pushHs && !(bypassActive && ready_out);
    assign headEn       = popHs && !bypassActive;
`else
    // Outputs come purely from registered state, giving one cycle minimum
    // latency from push to visibility.
    assign valid_out = !empty && !flush;
    assign data_out  = storage_q[headPtr];
    assign storeEn   = pushHs;
    assign headEn    = popHs;
`endif

    assign op = fifoOp_e'({storeEn, headEn});

    // Occupancy update. Flush empties the buffer regardless of handshakes;
    // simultaneous push and pop leave the count unchanged, which is what keeps
    // full-rate streaming possible at DEPTH.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            unique case (op)
                OP_PUSH: count_d = count_q + CNT_W'(1);
                OP_POP:  count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Occupancy register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Payload storage. When full with push+pop, tail equals head: the old
    // head is read out this cycle and overwritten on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                storage_q[i] <= '0;
            end
        end else if (storeEn) begin
            storage_q[tailPtr] <= data_in;
        end
    end

    // Read pointer.
    wrap_counter #(
        .MOD (DEPTH),
        .W   (PTR_W)
    ) u_headCounter (
        .clk     (clk),
        .reset   (reset),
        .clear_i (flush),
        .en_i    (headEn),
        .value_o (headPtr)
    );

    // Write pointer.
    wrap_counter #(
        .MOD (DEPTH),
        .W   (PTR_W)
    ) u_tailCounter (
        .clk     (clk),
        .reset   (reset),
        .clear_i (flush),
        .en_i    (storeEn),
        .value_o (tailPtr)
    );

endmodule
